capture_sequencer: RTL

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/capture_pkg.sv | 17 +
 rtl/trig_detect.sv | 35 +++
 rtl/capture_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared types and default sizes for the ADC capture sequencer.
package capture_pkg;

    localparam int DEF_DATA_W = 14;
    localparam int DEF_ADDR_W = 11;
    localparam int CAPT_DEPTH = 2 ** DEF_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        WAIT_TRIG,
        CAPTURE,
        DONE,
        HOLD
    } capt_state_t;

endpackage

// File: rtl/trig_detect.sv
// Threshold comparator with a two-deep history; reports the crossing edge
// selected by rising (1 = low-to-high, 0 = high-to-low).
module trig_detect
    import capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_adc,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [DATA_W-1:0] level,
    input  logic              rising,
    input  logic              clear,
    output logic              trigger
);

    logic t1_reg;
    logic t2_reg;

    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset) begin
            t1_reg <= 1'b0;
            t2_reg <= 1'b0;
        end else if (clear) begin
            t1_reg <= 1'b0;
            t2_reg <= 1'b0;
        end else begin
            t1_reg <= (adc_data >= level);
            t2_reg <= t1_reg;
        end
    end

    assign trigger = rising ? (t1_reg & ~t2_reg) : (~t1_reg & t2_reg);

endmodule

// File: rtl/capture_sequencer.sv
// Arm / trigger / capture sequencer writing one buffer of ADC samples to RAM.
// Define AUTO_TRIG_EN to force a capture after AUTO_TIMEOUT cycles without a trigger.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic              clk_adc,
    input  logic              reset,
    input  logic              enable,
    input  logic              single,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              done_ack,
    output logic              write_enable,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              capture_done,
    output logic              busy,
    output logic              trig_forced
);

    capt_state_t       state_reg;
    logic              arm_cnt_reg;
    logic [DATA_W-1:0] level_reg;
    logic              rising_reg;
    logic              arm_clear;
    logic              trigger;
    logic              timeout_hit;

    assign arm_clear = (state_reg == ARMED);

    trig_detect #(
        .DATA_W(DATA_W)
    ) u_trig_detect (
        .clk_adc (clk_adc),
        .reset   (reset),
        .adc_data(adc_data),
        .level   (level_reg),
        .rising  (rising_reg),
        .clear   (arm_clear),
        .trigger (trigger)
    );

`ifdef AUTO_TRIG_EN
    localparam int TO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT + 1) : 1;

    logic [TO_W-1:0] timeout_cnt_reg;
    logic            trig_forced_reg;

    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset) begin
            timeout_cnt_reg <= '0;
        end else if (state_reg == WAIT_TRIG) begin
            timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
        end else begin
            timeout_cnt_reg <= '0;
        end
    end

    assign timeout_hit = (timeout_cnt_reg == TO_W'(AUTO_TIMEOUT - 1));

    // The forced flag describes the buffer in flight, so it lives until the next arm.
    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset) begin
            trig_forced_reg <= 1'b0;
        end else if ((state_reg == IDLE && enable) ||
                     (state_reg == DONE && done_ack && enable && !single)) begin
            trig_forced_reg <= 1'b0;
        end else if (state_reg == WAIT_TRIG && enable && !trigger && timeout_hit) begin
            trig_forced_reg <= 1'b1;
        end
    end

    assign trig_forced = trig_forced_reg;
`else
    // No timeout hardware: waiting for a trigger is unbounded.
    assign timeout_hit = 1'b0 && (AUTO_TIMEOUT != 0);
    assign trig_forced = 1'b0;
`endif

    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset) begin
            wr_data <= '0;
        end else begin
            wr_data <= adc_data;
        end
    end

    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            arm_cnt_reg  <= 1'b0;
            level_reg    <= '0;
            rising_reg   <= 1'b0;
            write_enable <= 1'b0;
            wr_addr      <= '0;
            capture_done <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg   <= ARMED;
                        arm_cnt_reg <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ARMED: begin
                    level_reg  <= trig_level;
                    rising_reg <= trig_rising;
                    if (!enable) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else if (arm_cnt_reg) begin
                        state_reg <= WAIT_TRIG;
                    end else begin
                        arm_cnt_reg <= 1'b1;
                    end
                end
                WAIT_TRIG: begin
                    if (!enable) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else if (trigger || timeout_hit) begin
                        state_reg    <= CAPTURE;
                        write_enable <= 1'b1;
                        wr_addr      <= '0;
                    end
                end
                CAPTURE: begin
                    if (!enable) begin
                        state_reg    <= IDLE;
                        busy         <= 1'b0;
                        write_enable <= 1'b0;
                        wr_addr      <= '0;
                    end else if (&wr_addr) begin
                        // Last address just written: stop before the counter wraps.
                        state_reg    <= DONE;
                        busy         <= 1'b0;
                        write_enable <= 1'b0;
                        wr_addr      <= '0;
                        capture_done <= 1'b1;
                    end else begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                    end
                end
                DONE: begin
                    if (done_ack) begin
                        capture_done <= 1'b0;
                        if (!enable) begin
                            state_reg <= IDLE;
                        end else if (single) begin
                            state_reg <= HOLD;
                        end else begin
                            state_reg   <= ARMED;
                            arm_cnt_reg <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!enable) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    busy         <= 1'b0;
                    write_enable <= 1'b0;
                    wr_addr      <= '0;
                    capture_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
